// File: rtl/mult_fp_seq.sv
// Sequential floating-point multiplier with one-bit-per-cycle shift-add
// mantissa product, round-to-nearest-even, denormals-as-zero and full
// Inf/NaN/overflow/underflow handling. Flags are packed {N,Z,C,V}.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; once raised, out_valid stays high with res_mult/flags_mult
// stable until it is accepted, and in_ready is high only while idle.
module mult_fp_seq #(
  parameter int MANTISA_WIDTH  = 23,
  parameter int EXPONENT_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0]   a,
  input  logic [MANTISA_WIDTH+EXPONENT_WIDTH:0]   b,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [MANTISA_WIDTH+EXPONENT_WIDTH:0]   res_mult,
  output logic [3:0]                              flags_mult
);
  localparam int M  = MANTISA_WIDTH;
  localparam int E  = EXPONENT_WIDTH;
  localparam int W  = M + E + 1;
  localparam int PW = 2 * M + 2;
  localparam int EW = E + 2;
  localparam int CW = $clog2(M + 1);
  localparam logic [EW-1:0] BIAS     = EW'((1 << (E - 1)) - 1);
  localparam logic [EW-1:0] EMAX     = EW'((1 << E) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(M);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;          // operand A (fraction is the multiplicand)
  logic [E:0]    bse_q, bse_d;      // operand B sign/exponent; its fraction lives in prod_q
  logic [PW-1:0] prod_q, prod_d;    // partial product in the top, multiplier bits in the bottom
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] exp_q, exp_d;      // signed working exponent
  logic [M-1:0]  frac_q, frac_d;
  logic          guard_q, guard_d;
  logic          sticky_q, sticky_d;
  logic [W-1:0]  res_q, res_d;
  logic [3:0]    flags_q, flags_d;

  // Classification of the operands as presented, so specials finish on the accept edge
  logic [E-1:0] ea_in, eb_in;
  logic [M-1:0] fa_in, fb_in;
  logic         sign_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special_in;
  assign ea_in      = a[W-2:M];
  assign eb_in      = b[W-2:M];
  assign fa_in      = a[M-1:0];
  assign fb_in      = b[M-1:0];
  assign sign_in    = a[W-1] ^ b[W-1];
  assign a_zero     = (ea_in == '0);
  assign b_zero     = (eb_in == '0);
  assign a_inf      = (&ea_in) && (fa_in == '0);
  assign b_inf      = (&eb_in) && (fb_in == '0);
  assign a_nan      = (&ea_in) && (fa_in != '0);
  assign b_nan      = (&eb_in) && (fb_in != '0);
  assign special_in = a_zero | b_zero | (&ea_in) | (&eb_in);

  // Result and flags for zero / Inf / NaN operands
  logic [W-1:0] spec_res;
  logic [3:0]   spec_flags;
  always_comb begin
    spec_res = {sign_in, {(W-1){1'b0}}};
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
      spec_res = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    else if (a_inf | b_inf)
      spec_res = {sign_in, {E{1'b1}}, {M{1'b0}}};
    spec_flags = {spec_res[W-1], (spec_res[W-2:0] == '0), 2'b00};
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set, then shift right
  logic [M+1:0]  add_sum;
  logic [PW-1:0] step_prod;
  always_comb begin
    add_sum   = {1'b0, prod_q[PW-1:M+1]} + {2'b01, a_q[M-1:0]};
    step_prod = prod_q[0] ? {add_sum, prod_q[M:1]} : {1'b0, prod_q[PW-1:1]};
  end

  // Normalisation: pick the fraction window and derive guard/sticky from the full product
  logic [EW-1:0] exp_sum, norm_exp;
  logic [M-1:0]  norm_frac;
  logic          norm_guard, norm_sticky;
  always_comb begin
    exp_sum = {2'b00, a_q[W-2:M]} + {1'b0, 1'b0, bse_q[E-1:0]} - BIAS;
    if (prod_q[PW-1]) begin
      norm_exp    = exp_sum + EW'(1);
      norm_frac   = prod_q[2*M:M+1];
      norm_guard  = prod_q[M];
      norm_sticky = |prod_q[M-1:0];
    end else begin
      norm_exp    = exp_sum;
      norm_frac   = prod_q[2*M-1:M];
      norm_guard  = prod_q[M-1];
      norm_sticky = |prod_q[M-2:0];
    end
  end

  // Nearest-even rounding followed by overflow/underflow resolution
  logic          round_up, sign_r, inexact, ovf, unf;
  logic [M:0]    frac_sum;
  logic [EW-1:0] exp_rnd;
  logic [W-1:0]  rnd_res;
  logic [3:0]    rnd_flags;
  always_comb begin
    round_up = guard_q & (sticky_q | frac_q[0]);
    frac_sum = {1'b0, frac_q} + {{M{1'b0}}, round_up};
    exp_rnd  = exp_q + {{(EW-1){1'b0}}, frac_sum[M]};
    sign_r   = a_q[W-1] ^ bse_q[E];
    inexact  = guard_q | sticky_q;
    ovf      = ~exp_rnd[EW-1] & (exp_rnd >= EMAX);
    unf      = exp_rnd[EW-1] | (exp_rnd == '0);
    if (ovf) begin
      rnd_res   = {sign_r, {E{1'b1}}, {M{1'b0}}};
      rnd_flags = {sign_r, 1'b0, 1'b1, 1'b1};
    end else if (unf) begin
      rnd_res   = {sign_r, {(W-1){1'b0}}};
      rnd_flags = {sign_r, 1'b1, 1'b1, 1'b0};
    end else begin
      rnd_res   = {sign_r, exp_rnd[E-1:0], frac_sum[M-1:0]};
      rnd_flags = {sign_r, 1'b0, inexact, 1'b0};
    end
  end

  // Control FSM and datapath register updates
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    bse_d    = bse_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = a;
          bse_d  = {b[W-1], eb_in};
          prod_d = {{(M+1){1'b0}}, 1'b1, fb_in};
          cnt_d  = '0;
          if (special_in) begin
            res_d   = spec_res;
            flags_d = spec_flags;
            state_d = S_DONE;
          end else begin
            state_d = S_MULT;
          end
        end
      end
      S_MULT: begin
        prod_d = step_prod;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NORM: begin
        exp_d    = norm_exp;
        frac_d   = norm_frac;
        guard_d  = norm_guard;
        sticky_d = norm_sticky;
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        res_d   = rnd_res;
        flags_d = rnd_flags;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      bse_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      frac_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      bse_q    <= bse_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign res_mult   = res_q;
  assign flags_mult = flags_q;
endmodule

// File: tb/tb_mult_fp_seq.sv
// Self-checking bench for mult_fp_seq: directed and random binary32 products
// against a behavioural model, backpressure, mid-operation reset, and one
// binary64 instance.
module tb_mult_fp_seq;
  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default-parameter (binary32) instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, res_mult;
  logic [3:0]  flags_mult;

  mult_fp_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res_mult(res_mult), .flags_mult(flags_mult)
  );

  // binary64 instance
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] a64, b64, res64;
  logic [3:0]  flags64;

  mult_fp_seq #(.MANTISA_WIDTH(52), .EXPONENT_WIDTH(11)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
    .res_mult(res64), .flags_mult(flags64)
  );

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];   // {res, flags} expected, in issue order
  logic [35:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference model: exact integer product, round-half-even on the discarded remainder
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    int ea, eb, e, sh;
    logic s, za, zb, ia, ib, na, nb, inexact;
    longint unsigned pa, pb, p, keep, rem, half;
    s  = x[31] ^ y[31];
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (x[22:0] == 0);
    ib = (eb == 255) && (y[22:0] == 0);
    na = (ea == 255) && (x[22:0] != 0);
    nb = (eb == 255) && (y[22:0] != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {32'h7FC0_0000, 4'b0000};
    if (ia || ib) return {s, 8'hFF, 23'h0, s, 3'b000};
    if (za || zb) return {s, 31'h0, s, 3'b100};
    pa = 64'h80_0000 | 64'(x[22:0]);
    pb = 64'h80_0000 | 64'(y[22:0]);
    p  = pa * pb;
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    keep    = p >> sh;
    rem     = p & ((64'd1 << sh) - 1);
    half    = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, s, 3'b011};
    if (e <= 0)   return {s, 31'h0, s, 3'b110};
    return {s, e[7:0], keep[22:0], s, 1'b0, inexact, 1'b0};
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected no result", res_mult);
      end else begin
        mon_e = exp_q[0];
        check("res_mult", 64'(res_mult), 64'(mon_e[35:4]));
        check("flags_mult", 64'(flags_mult), 64'(mon_e[3:0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: issue one operation, check latency, optional backpressure, handshake
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input int exp_lat, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = ta;
    b = tb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(model(ta, tb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      check("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 64'(out_valid), 64'd1);
      exp_q.delete();
      return;
    end
    check("latency", 64'(n), 64'(exp_lat));
    repeat (hold) begin
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: begin
        v[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0;
      end
      2: v[30:23] = 8'($urandom_range(1, 20));
      3: v[30:23] = 8'($urandom_range(230, 254));
      4: begin
        v[30:23] = 8'($urandom_range(100, 154));
        v[22:0]  = 23'h7FFFFF;
      end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  function automatic bit is_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
  endfunction

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    logic [31:0] ra, rb;
    int n;
    bit seen;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res_mult), 64'd0);
    check("rst_flags", 64'(flags_mult), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model itself to hand-computed values
    check("model_2x3", 64'(model(32'h4000_0000, 32'h4040_0000)), {28'h0, 32'h40C0_0000, 4'b0000});
    check("model_neg", 64'(model(32'hBFC0_0000, 32'h4000_0000)), {28'h0, 32'hC040_0000, 4'b1000});
    check("model_rne", 64'(model(32'h3F80_0001, 32'h3F80_0001)), {28'h0, 32'h3F80_0002, 4'b0010});
    check("model_0xinf", 64'(model(32'h0000_0000, 32'h7F80_0000)), {28'h0, 32'h7FC0_0000, 4'b0000});
    check("model_infxn", 64'(model(32'h7F80_0000, 32'hC000_0000)), {28'h0, 32'hFF80_0000, 4'b1000});
    check("model_daz", 64'(model(32'h0000_0001, 32'h4000_0000)), {28'h0, 32'h0000_0000, 4'b0100});
    check("model_ovf", 64'(model(32'h7F00_0000, 32'h7F00_0000)), {28'h0, 32'h7F80_0000, 4'b0011});
    check("model_unf", 64'(model(32'h0080_0000, 32'h0080_0000)), {28'h0, 32'h0000_0000, 4'b0110});

    // Directed cases; specials are registered on the accepting edge itself
    do_op(32'h4000_0000, 32'h4040_0000, 26, 0);
    do_op(32'hBFC0_0000, 32'h4000_0000, 26, 0);
    do_op(32'h3F80_0001, 32'h3F80_0001, 26, 0);
    do_op(32'h0000_0000, 32'h7F80_0000, 0, 0);
    do_op(32'h7F80_0000, 32'hC000_0000, 0, 0);
    do_op(32'h0000_0001, 32'h4000_0000, 0, 0);
    do_op(32'h7F00_0000, 32'h7F00_0000, 26, 0);
    do_op(32'h0080_0000, 32'h0080_0000, 26, 0);

    // Backpressure: ten cycles of out_ready low
    do_op(32'h4000_0000, 32'h4040_0000, 26, 10);

    // Reset during MULT: aborts, clears outputs, no result appears
    a = 32'h4000_0000;
    b = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_res", 64'(res_mult), 64'd0);
    check("abort_flags", 64'(flags_mult), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    do_op(32'h4000_0000, 32'h4040_0000, 26, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      do_op(ra, rb, (is_special(ra) || is_special(rb)) ? 0 : 26, int'($urandom_range(0, 3)));
    end

    // binary64: 2.0 x 3.0
    a64 = 64'h4000_0000_0000_0000;
    b64 = 64'h4008_0000_0000_0000;
    in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    n = 0;
    while (!out_valid64 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("lat64", 64'(n), 64'd55);
    check("res64", res64, 64'h4018_0000_0000_0000);
    check("flags64", 64'(flags64), 64'd0);
    @(posedge clk); #1;
    check("out_valid64_drop", 64'(out_valid64), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_fp_seq.md
Name: mult_fp_seq

Overview:
- Sequential, parametrised IEEE-754-style floating-point multiplier. It is the multi-cycle successor of the combinational FP multiplier in the FP unit.
- Mantissas are multiplied with an iterative shift-add datapath, one bit per cycle. The block adds round-to-nearest-even and full special-value handling: zero, denormal-as-zero, infinity, NaN, overflow, underflow.
- Operands enter and results leave over valid/ready handshakes. Flags use the same NZCV packing as the rest of the FP unit.

Parameters:
- MANTISA_WIDTH, 23, stored fraction bits (M).
- EXPONENT_WIDTH, 8, exponent bits (E); bias = 2^(E-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  M+E+1  operand A {sign, exp, frac}.
- b  in  M+E+1  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- res_mult  out  M+E+1  product.
- flags_mult  out  4  {N,Z,C,V}.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, res_mult=0, flags_mult=0.
  - Internal registers are cleared.
  - Reset asserted mid-operation aborts the operation; no result is emitted.
- Acceptance: an operation is accepted on a clk edge where in_valid&in_ready (edge E0).
  - a and b are latched.
  - in_ready=1 only in IDLE; there is no overlap of operations.
- FSM states: IDLE, MULT, NORM, ROUND, DONE.
  - IDLE -> MULT on accept, for normal operands.
  - IDLE -> DONE on accept, for special operands. Result is valid after 1 edge.
  - MULT runs M+1 cycles. Each cycle: if the multiplier LSB is 1, add the multiplicand to the 2M+2-bit partial product, then shift. A counter counts 0..M.
  - MULT -> NORM -> ROUND -> DONE.
  - Normal latency: out_valid rises M+3 edges after E0 (26 for defaults).
  - DONE: res_mult and flags_mult are held stable while out_valid=1 and out_ready=0.
  - DONE -> IDLE on out_valid&out_ready. out_valid drops on the same edge.
- Operand classification (from latched a, b):
  - exp=0 is treated as zero; the fraction is ignored (denormals-are-zero).
  - exp=all-ones with frac=0 is Inf; with frac≠0 it is NaN.
- Special results:
  - Any NaN, or Inf×0: canonical quiet NaN {0, all-ones, 1, 0...}. Flags 0000.
  - Inf×finite-nonzero or Inf×Inf: {sa^sb, all-ones, 0}. V=0.
  - Zero×finite: {sa^sb, 0, 0}. Z=1.
- Normal path:
  - Result sign = sa^sb.
  - Exponent is signed, E+2 bits wide: e = ea + eb - bias.
  - NORM: if product bit 2M+1 = 1, e+=1 and take fraction bits [2M:M+1]. Otherwise take bits [2M-1:M].
  - Guard = next lower bit. Sticky = OR of all remaining lower bits.
  - ROUND (nearest-even): increment the fraction if guard & (sticky | fraction LSB).
  - If rounding carries out of the fraction: fraction=0, e+=1.
  - Overflow, e >= 2^E-1: result = signed Inf, V=1, C=1.
  - Underflow, e <= 0: result = signed zero (flush), Z=1, C=1.
- Flags:
  - N = res_mult sign bit.
  - Z = result is ±0.
  - C = inexact: guard|sticky nonzero, or overflow/underflow occurred.
  - V = exponent overflow.
- Outputs change only on entering DONE or on reset.

Test Plan:
- 2.0×3.0: a=0x40000000, b=0x40400000, defaults.
  -> res=0x40C00000, flags=0000, out_valid exactly 26 edges after accept. in_ready=0 throughout.
- Sign / NZCV: a=0xBFC00000 (-1.5), b=0x40000000.
  -> res=0xC0400000, flags=1000.
- Rounding, nearest-even inexact: a=b=0x3F800001.
  -> res=0x3F800002, flags=0010.
- Specials:
  - 0x00000000×0x7F800000 -> 0x7FC00000, flags 0000, valid after 1 edge.
  - 0x7F800000×0xC0000000 -> 0xFF800000, flags 1000.
  - 0x00000001 (denormal)×0x40000000 -> 0x00000000, flags 0100.
- Overflow/underflow:
  - 0x7F000000×0x7F000000 -> 0x7F800000, flags 0011.
  - 0x00800000×0x00800000 -> 0x00000000, flags 0110.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after out_valid. Result stays stable and in_ready stays 0. Release: one handshake, then in_ready=1 next cycle.
  - Separately, pull rst_n low during MULT. out_valid stays 0, all outputs read 0, and a new op after reset completes correctly.
  - Rerun the 2.0×3.0 case with MANTISA_WIDTH=52, EXPONENT_WIDTH=11 -> 0x4018000000000000, latency 55.
